// File: rtl/serial_subtractor_8bit_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit_pkg
//   Shared definitions for the bit-serial subtractor:
//     - DEFAULT_WIDTH : default operand/result width
//     - state_t       : control FSM encoding (IDLE, SHIFT, DONE)
//     - cnt_width()   : bit-counter width for a given operand width
// ---------------------------------------------------------------------------
package serial_subtractor_8bit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter walks bit positions 0..width-1, so it needs clog2(width)
  // bits. A one-bit counter is kept as the floor so the vector stays legal.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/FullAdder.sv
// ---------------------------------------------------------------------------
// FullAdder
//   One-bit full adder cell shared with the combinational ripple adder.
//   Ports:
//     a, b  : addend bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out
// ---------------------------------------------------------------------------
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit
//   Bit-serial two's-complement subtractor: diff = x - y - b_in, one bit per
//   clock, built around a single FullAdder cell computing x + ~y + ~b_in.
//
//   Ports:
//     clk       : rising-edge clock
//     rst       : asynchronous, active-high reset
//     start     : request; accepted only on an edge where the FSM is in IDLE
//                 or DONE
//     x, y      : minuend / subtrahend, latched on the accepting edge
//     b_in      : borrow in, latched on the accepting edge
//     busy      : high while the serial computation is in progress
//     done      : one-cycle pulse; diff/borrow/overflow valid from this cycle
//     diff      : registered result, held until the next completion
//     borrow    : unsigned borrow out (NOT of the final carry)
//     overflow  : signed overflow (carry into MSB XOR carry out of MSB)
//
//   Handshake: start acts as a request with implicit ready = !busy. A request
//   is taken on any rising edge where the block is idle or in its done cycle
//   (so back-to-back operations need no bubble); start while busy is ignored.
//   done is a single-cycle valid strobe; the result registers then hold their
//   value until the next done.
// ---------------------------------------------------------------------------
module serial_subtractor_8bit
  import serial_subtractor_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int              CNT_W        = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB_PREV = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  state_t state;
  state_t state_next;
  logic   accept;
  logic   last_step;

  // Datapath registers
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic             c_msb_in;
  logic [CNT_W-1:0] cnt;

  // FullAdder outputs for the bit currently at the bottom of the shifters
  logic fa_s;
  logic fa_cout;

  // The MSB is processed on the edge where the counter sits at WIDTH-1.
  assign last_step = (state == SHIFT) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      // Status flags are registered copies of the next state so they carry
      // no combinational path from start.
      busy  <= (state_next == SHIFT);
      done  <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          accept     = 1'b1;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Done lasts one cycle; a request here starts the next operation
        // immediately, otherwise fall back to idle.
        if (start) begin
          state_next = SHIFT;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Serial datapath
  // -------------------------------------------------------------------------
  FullAdder u_full_adder (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // Subtraction as x + ~y + ~b_in: the inverted borrow seeds the carry.
      a_sh     <= x;
      b_sh     <= ~y;
      r_sh     <= '0;
      carry    <= ~b_in;
      c_msb_in <= 1'b0;
      cnt      <= '0;
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= {fa_s, r_sh[WIDTH-1:1]};
      carry <= fa_cout;
      cnt   <= cnt + CNT_ONE;

      // Carry out of bit WIDTH-2 is the carry into the MSB, needed later
      // for the signed overflow flag.
      if (cnt == CNT_MSB_PREV) begin
        c_msb_in <= fa_cout;
      end

      // The result registers only move on the completing edge, with the
      // MSB sum bit taken straight from the adder.
      if (last_step) begin
        diff     <= {fa_s, r_sh[WIDTH-1:1]};
        borrow   <= ~fa_cout;
        overflow <= c_msb_in ^ fa_cout;
      end
    end
  end

endmodule
